// File: rtl/clk_div_bank_if.sv
// Control/observation bundle for clk_div_bank: config, enable/sync in; divided clocks, ticks, lock out.
interface clk_div_bank_if #(
  parameter int unsigned NUM_OUT = 3,
  parameter int unsigned CNT_W   = 8
);
  logic                     enable;
  logic                     sync;
  logic                     cfg_load;
  logic [NUM_OUT*CNT_W-1:0] cfg_half;
  logic [NUM_OUT-1:0]       clk_out;
  logic [NUM_OUT-1:0]       tick;
  logic                     locked;

  modport master (
    output enable, sync, cfg_load, cfg_half,
    input  clk_out, tick, locked
  );

  modport slave (
    input  enable, sync, cfg_load, cfg_half,
    output clk_out, tick, locked
  );
endinterface

// File: rtl/clk_div_bank.sv
// Bank of NUM_OUT programmable 50%-duty clock dividers sharing clk_in.
// Ratio changes are held in a shadow register and applied only on the
// falling edge of the divided clock (or immediately on sync), so no
// high/low phase is ever truncated.
module clk_div_bank #(
  parameter int unsigned NUM_OUT = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic         clk_in,
  input  logic         reset_L,
  clk_div_bank_if.slave bus
);

  logic [CNT_W-1:0]   half_q   [NUM_OUT];
  logic [CNT_W-1:0]   half_d   [NUM_OUT];
  logic [CNT_W-1:0]   shadow_q [NUM_OUT];
  logic [CNT_W-1:0]   shadow_d [NUM_OUT];
  logic [CNT_W-1:0]   cnt_q    [NUM_OUT];
  logic [CNT_W-1:0]   cnt_d    [NUM_OUT];
  logic [CNT_W-1:0]   cfg_ch   [NUM_OUT];
  logic [NUM_OUT-1:0] pending_q, pending_d;
  logic [NUM_OUT-1:0] clk_q, clk_d;
  logic [NUM_OUT-1:0] tick_q, tick_d;

  // Per-channel next state: sync > freeze > off channel > run; config capture last.
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      cfg_ch[i]    = bus.cfg_half[i*CNT_W +: CNT_W];
      half_d[i]    = half_q[i];
      shadow_d[i]  = shadow_q[i];
      cnt_d[i]     = cnt_q[i];
      pending_d[i] = pending_q[i];
      clk_d[i]     = clk_q[i];
      tick_d[i]    = 1'b0;

      if (bus.sync) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        if (pending_q[i]) begin
          half_d[i]    = shadow_q[i];
          pending_d[i] = 1'b0;
        end
      end else if (bus.enable) begin
        if (half_q[i] == '0) begin
          // Off channel: parked low; a pending ratio starts it from phase 0.
          cnt_d[i] = '0;
          clk_d[i] = 1'b0;
          if (pending_q[i]) begin
            half_d[i]    = shadow_q[i];
            pending_d[i] = 1'b0;
          end
        end else if (cnt_q[i] == half_q[i] - CNT_W'(1)) begin
          cnt_d[i]  = '0;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = ~clk_q[i];
          // Falling edge is the period boundary: safe point to swap ratios.
          if (clk_q[i] && pending_q[i]) begin
            half_d[i]    = shadow_q[i];
            pending_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end

      // Compare against the ratio in force after this edge, so a load that
      // coincides with a boundary stays pending until the following one.
      if (bus.cfg_load) begin
        shadow_d[i]  = cfg_ch[i];
        pending_d[i] = (cfg_ch[i] != half_d[i]);
      end
    end
  end

  // State registers; reset loads default ratios half[i] = 2^i.
  always_ff @(posedge clk_in or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        half_q[i]   <= CNT_W'(1) << i;
        shadow_q[i] <= CNT_W'(1) << i;
        cnt_q[i]    <= '0;
      end
      pending_q <= '0;
      clk_q     <= '0;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        half_q[i]   <= half_d[i];
        shadow_q[i] <= shadow_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      pending_q <= pending_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.clk_out = clk_q;
  assign bus.tick    = tick_q;
  assign bus.locked  = ~|pending_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: defaults, glitch-free reload, channel off,
// freeze, sync realignment and asynchronous reset.
module tb_clk_div_bank;

  localparam int unsigned NUM_OUT = 3;
  localparam int unsigned CNT_W   = 8;

  logic        clk_in  = 1'b0;
  logic        reset_L = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n        = 0;

  clk_div_bank_if #(.NUM_OUT(NUM_OUT), .CNT_W(CNT_W)) bus ();

  clk_div_bank #(.NUM_OUT(NUM_OUT), .CNT_W(CNT_W)) dut (
    .clk_in  (clk_in),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  always #10 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic edge_step();
    @(posedge clk_in);
    #1;
    n++;
  endtask

  task automatic load(input logic [NUM_OUT*CNT_W-1:0] v);
    bus.cfg_half = v;
    bus.cfg_load = 1'b1;
    edge_step();
    bus.cfg_load = 1'b0;
  endtask

  // Expected clk_out / tick after edges 1..8 with default ratios /2, /4, /8.
  logic [2:0] def_clk  [8] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000};
  logic [2:0] def_tick [8] = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010, 3'b001, 3'b000};
  // clk_out[1] after edges 13..21 once ch1 switches to half=3 at edge 12.
  logic       ch1_exp  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [2:0] exp;
    bus.enable   = 1'b0;
    bus.sync     = 1'b0;
    bus.cfg_load = 1'b0;
    bus.cfg_half = '0;

    // Reset state
    #5;
    check("rst_clk",    32'(bus.clk_out), 32'h0);
    check("rst_tick",   32'(bus.tick),    32'h0);
    check("rst_locked", 32'(bus.locked),  32'h1);

    @(negedge clk_in);
    reset_L    = 1'b1;
    bus.enable = 1'b1;

    // Default ratios
    for (int e = 0; e < 8; e++) begin
      edge_step();
      check($sformatf("def_clk%0d", e + 1),  32'(bus.clk_out), 32'(def_clk[e]));
      check($sformatf("def_tick%0d", e + 1), 32'(bus.tick),    32'(def_tick[e]));
    end

    // Reload ch1 to 3 while clk_out[1] is high
    edge_step();
    edge_step();
    check("pre_load_clk", 32'(bus.clk_out), 32'h2);
    load({8'd4, 8'd3, 8'd1});
    check("ld1_locked0", 32'(bus.locked),  32'h0);
    check("ld1_clk",     32'(bus.clk_out), 32'h3);
    edge_step();
    check("ld1_locked1", 32'(bus.locked),  32'h1);
    check("ld1_fall",    32'(bus.clk_out), 32'h4);
    for (int k = 0; k < 9; k++) begin
      edge_step();
      exp = {n[2], ch1_exp[k], n[0]};
      check($sformatf("ch1_3_clk%0d", n), 32'(bus.clk_out), 32'(exp));
      check($sformatf("ch1_3_tick%0d", n), 32'(bus.tick[1]), 32'((k == 2) || (k == 8)));
    end

    // Turn ch2 off, then back on at /2
    load({8'd0, 8'd3, 8'd1});
    check("off_locked0", 32'(bus.locked), 32'h0);
    for (int k = 0; k < 10; k++) begin
      edge_step();
      check($sformatf("off_clk2_%0d", n), 32'(bus.clk_out[2]), 32'(n == 23));
      check($sformatf("off_tick2_%0d", n), 32'(bus.tick[2]), 32'h0);
      if (n == 24) check("off_locked1", 32'(bus.locked), 32'h1);
    end
    load({8'd1, 8'd3, 8'd1});
    check("on_locked0", 32'(bus.locked), 32'h0);
    edge_step();
    check("on_locked1", 32'(bus.locked),     32'h1);
    check("on_clk2_a",  32'(bus.clk_out[2]), 32'h0);
    edge_step();
    check("on_clk2_b",  32'(bus.clk_out[2]), 32'h1);
    check("on_tick2",   32'(bus.tick[2]),    32'h1);
    edge_step();
    check("on_clk2_c",  32'(bus.clk_out[2]), 32'h0);
    edge_step();
    check("on_clk_all", 32'(bus.clk_out),    32'h5);

    // Freeze for 5 cycles mid-phase
    bus.enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      edge_step();
      check($sformatf("frz_clk%0d", k),  32'(bus.clk_out), 32'h5);
      check($sformatf("frz_tick%0d", k), 32'(bus.tick),    32'h0);
    end
    bus.enable = 1'b1;
    edge_step();
    check("res_clk1_a", 32'(bus.clk_out[1]), 32'h0);
    check("res_clk0_a", 32'(bus.clk_out[0]), 32'h0);
    edge_step();
    check("res_clk1_b", 32'(bus.clk_out[1]), 32'h1);
    check("res_tick1",  32'(bus.tick[1]),    32'h1);

    // Sync with ch0=2 pending
    load({8'd1, 8'd3, 8'd2});
    check("sync_pend", 32'(bus.locked), 32'h0);
    bus.sync = 1'b1;
    edge_step();
    bus.sync = 1'b0;
    check("sync_clk",    32'(bus.clk_out), 32'h0);
    check("sync_tick",   32'(bus.tick),    32'h0);
    check("sync_locked", 32'(bus.locked),  32'h1);
    edge_step();
    check("sync_clk1",  32'(bus.clk_out), 32'h4);
    check("sync_tick1", 32'(bus.tick),    32'h4);
    edge_step();
    check("sync_clk2",  32'(bus.clk_out), 32'h1);
    check("sync_tick2", 32'(bus.tick),    32'h1);
    edge_step();
    check("sync_clk3",  32'(bus.clk_out), 32'h7);
    check("sync_tick3", 32'(bus.tick),    32'h6);

    // Asynchronous reset mid-cycle with configs pending
    load({8'd4, 8'd2, 8'd1});
    check("pre_rst_locked", 32'(bus.locked),  32'h0);
    check("pre_rst_clk",    32'(bus.clk_out), 32'h2);
    #4;
    reset_L = 1'b0;
    #1;
    check("arst_clk",    32'(bus.clk_out), 32'h0);
    check("arst_tick",   32'(bus.tick),    32'h0);
    check("arst_locked", 32'(bus.locked),  32'h1);
    @(negedge clk_in);
    reset_L = 1'b1;
    n = 0;
    for (int e = 0; e < 4; e++) begin
      edge_step();
      check($sformatf("rel_clk%0d", e + 1),  32'(bus.clk_out), 32'(def_clk[e]));
      check($sformatf("rel_tick%0d", e + 1), 32'(bus.tick),    32'(def_tick[e]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
